// File: rtl/sobel_stream_pio.sv
// Avalon-MM slave feeding a FWFT FIFO that drains over valid/ready into the Sobel core,
// plus a byte-enabled static output register, status/control registers and overflow irq.
module sobel_stream_pio #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] OUT_RESET  = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [2:0]                address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [DATA_WIDTH-1:0]     writedata,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic [DATA_WIDTH-1:0]     out_port,
    output logic [DATA_WIDTH-1:0]     st_data,
    output logic                      st_valid,
    input  logic                      st_ready,
    output logic                      irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = DATA_WIDTH / 8;

    // Reset asserts immediately but releases only on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  en_q, en_d, irq_en_q, irq_en_d;
    logic                  ovf_q, ovf_d, irq_q;

    logic wr, push, pop, push_ok, flush, empty, full;

    assign wr      = chipselect & ~write_n;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign push    = wr && (address == 3'd0);
    assign pop     = st_valid & st_ready;
    assign push_ok = push && (!full || pop);
    assign flush   = wr && (address == 3'd2) && byteenable[0] && writedata[1];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        out_d    = out_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);
        if (push) hold_d = writedata;

        // Clear first so a coincident set wins.
        if (wr && (address == 3'd1) && writedata[2]) ovf_d = 1'b0;
        if (push && full && !pop)                    ovf_d = 1'b1;

        if (wr && (address == 3'd2) && byteenable[0]) begin
            en_d     = writedata[0];
            irq_en_d = writedata[2];
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        if (wr && (address == 3'd3)) begin
            for (int i = 0; i < BW; i++)
                if (byteenable[i]) out_d[i*8 +: 8] = writedata[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            out_q    <= OUT_RESET;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            out_q    <= out_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            irq_q    <= ovf_d & irq_en_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= writedata;
    end

    assign st_valid = en_q & ~empty;
    assign st_data  = mem_q[rd_ptr_q];
    assign out_port = out_q;
    assign irq      = irq_q;

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata = hold_q;
            3'd1: begin
                readdata[0]       = empty;
                readdata[1]       = full;
                readdata[2]       = ovf_q;
                readdata[8 +: CW] = count_q;
            end
            3'd2: begin
                readdata[0] = en_q;
                readdata[2] = irq_en_q;
            end
            3'd3:    readdata = out_q;
            default: readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_sobel_stream_pio.sv
// Randomised and directed bench for sobel_stream_pio against a queue-based reference model.
module tb_sobel_stream_pio;
    localparam int          DW    = 32;
    localparam int          DEPTH = 16;
    localparam logic [31:0] OUTR  = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect, write_n, st_ready;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata, out_port, st_data;
    logic        st_valid, irq;

    sobel_stream_pio #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_RESET(OUTR)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .out_port(out_port), .st_data(st_data),
        .st_valid(st_valid), .st_ready(st_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mq[$];
    logic        m_ovf, m_en, m_irq_en;
    logic [31:0] m_hold, m_out;
    int          nvec = 0, nerr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r = m_hold;
            3'd1: begin
                r = 32'(mq.size()) << 8;
                r[0] = (mq.size() == 0);
                r[1] = (mq.size() == DEPTH);
                r[2] = m_ovf;
            end
            3'd2: r = {29'd0, m_irq_en, 1'b0, m_en};
            3'd3: r = m_out;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_en = 0; m_irq_en = 0; m_hold = '0; m_out = OUTR;
    endtask

    // One clock cycle: drive at the falling edge, check outputs, advance model, wait for next fall.
    task automatic cyc(input logic w, input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic r);
        logic pop, exp_valid;
        int   sz;
        address = a; chipselect = w; write_n = ~w; writedata = d; byteenable = b; st_ready = r;
        #1;
        exp_valid = m_en && (mq.size() > 0);
        check("st_valid", {31'd0, st_valid}, {31'd0, exp_valid});
        if (exp_valid) check("st_data", st_data, mq[0]);
        check($sformatf("readdata[a=%0d]", a), readdata, model_read(a));
        check("irq", {31'd0, irq}, {31'd0, m_ovf & m_irq_en});
        check("out_port", out_port, m_out);

        sz  = mq.size();
        pop = exp_valid && r;
        if (w && a == 3'd2 && b[0] && d[1]) begin
            mq.delete();
            m_en = d[0]; m_irq_en = d[2];
        end else begin
            if (pop) void'(mq.pop_front());
            if (w) begin
                case (a)
                    3'd0: begin
                        m_hold = d;
                        if (sz < DEPTH || pop) mq.push_back(d);
                        else m_ovf = 1'b1;
                    end
                    3'd1: if (d[2]) m_ovf = 1'b0;
                    3'd2: if (b[0]) begin m_en = d[0]; m_irq_en = d[2]; end
                    3'd3: for (int i = 0; i < 4; i++) if (b[i]) m_out[i*8 +: 8] = d[i*8 +: 8];
                    default: ;
                endcase
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [2:0] a, input logic r);
        cyc(1'b0, a, 32'h0, 4'h0, r);
    endtask

    initial begin
        logic [2:0]  ra;
        logic [31:0] rd;
        reset_n = 1'b0; address = '0; chipselect = 0; write_n = 1; writedata = '0;
        byteenable = '0; st_ready = 0;
        model_reset();
        repeat (3) @(negedge clk);
        idle(3'd1, 1'b0);
        idle(3'd3, 1'b0);
        reset_n = 1'b1;
        repeat (3) idle(3'd1, 1'b0);

        // Basic stream: enable + irq_en, three words held, then drained in order
        cyc(1, 3'd2, 32'h5, 4'h1, 0);
        cyc(1, 3'd0, 32'h11, 4'h0, 0);
        cyc(1, 3'd0, 32'h22, 4'hF, 0);
        cyc(1, 3'd0, 32'h33, 4'hF, 0);
        idle(3'd1, 0);
        idle(3'd0, 0);
        repeat (3) idle(3'd1, 1);
        idle(3'd1, 1);

        // Overflow: 17 pushes with no drain
        for (int i = 0; i < 17; i++) cyc(1, 3'd0, 32'h100 + i, 4'hF, 0);
        idle(3'd1, 0);
        cyc(1, 3'd1, 32'h4, 4'hF, 0);
        idle(3'd1, 0);

        // Full with simultaneous pop and push
        cyc(1, 3'd0, 32'hAA, 4'hF, 1);
        idle(3'd1, 0);
        repeat (17) idle(3'd1, 1);

        // Flush while draining
        for (int i = 0; i < 5; i++) cyc(1, 3'd0, 32'h200 + i, 4'hF, 0);
        cyc(1, 3'd2, 32'h3, 4'h1, 1);
        idle(3'd1, 1);
        idle(3'd2, 1);

        // Direct output register byte lanes and unmapped addresses
        cyc(1, 3'd3, 32'hDEADBEEF, 4'hF, 0);
        cyc(1, 3'd3, 32'h00000000, 4'h2, 0);
        idle(3'd3, 0);
        cyc(1, 3'd5, 32'hFFFFFFFF, 4'hF, 0);
        idle(3'd5, 0);
        idle(3'd7, 0);

        // Enable drop with contents retained
        for (int i = 0; i < 3; i++) cyc(1, 3'd0, 32'h300 + i, 4'hF, 1);
        cyc(1, 3'd2, 32'h4, 4'h1, 1);
        cyc(1, 3'd0, 32'h3FF, 4'hF, 1);
        idle(3'd1, 1);
        cyc(1, 3'd2, 32'h5, 4'h1, 1);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            ra = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 5) ra = 3'd0;
            rd = $urandom;
            if (ra == 3'd2) begin
                rd[0] = ($urandom_range(0, 3) != 0);
                rd[1] = ($urandom_range(0, 7) == 0);
            end
            cyc(1'($urandom_range(0, 1)), ra, rd, 4'($urandom), 1'($urandom_range(0, 2) == 0));
        end

        // Reset in the middle of traffic
        cyc(1, 3'd2, 32'h1, 4'h1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 3'd0, 32'h400 + i, 4'hF, 0);
        #3 reset_n = 1'b0;
        #1 check("st_valid_async_rst", {31'd0, st_valid}, 32'd0);
        model_reset();
        @(negedge clk);
        idle(3'd1, 1);
        reset_n = 1'b1;
        repeat (3) idle(3'd1, 1);
        idle(3'd3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
